// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, edge selection and the default underrun fill word.
package spi_pkg;

    typedef enum logic [1:0] {
        SpiMode0 = 2'b00,
        SpiMode1 = 2'b01,
        SpiMode2 = 2'b10,
        SpiMode3 = 2'b11
    } spi_mode_e;

    typedef struct packed {
        logic sample;
        logic shift;
    } spi_edge_t;

    localparam logic [31:0] FILL_WORD_DEFAULT = 32'h0000_00FF;

    // Leading edge leaves the idle level; CPHA picks which of the two edges samples.
    function automatic spi_edge_t edge_sel(input spi_mode_e mode, input logic sck_prev,
                                           input logic sck_now);
        logic      cpol;
        logic      cpha;
        logic      leading;
        logic      trailing;
        spi_edge_t e;
        {cpol, cpha} = mode;
        leading  = (sck_prev == cpol) && (sck_now != cpol);
        trailing = (sck_prev != cpol) && (sck_now == cpol);
        e.sample = cpha ? trailing : leading;
        e.shift  = cpha ? leading : trailing;
        return e;
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous TX FIFO with flush, occupancy level and not-full ready.
module spi_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk6x,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   pop_i,
    output logic [DATA_W-1:0]      head_o,
    output logic                   empty_o,
    output logic                   ready_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              push_ok;
    logic              pop_ok;

    assign empty_o = (level_q == '0);
    assign ready_o = (level_q != LVL_W'(DEPTH));
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Flush wins over both push and pop; no full-level bypass since ready gates the push.
    assign push_ok = push_i && ready_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    always_ff @(posedge clk6x) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spi_target_fifo.sv
// SPI target for the ICD/host link: oversampled SCK/CSN/MOSI, any SPI mode, parametric word
// width, TX FIFO feeding the shift register with a fill word on underrun.
module spi_target_fifo
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter bit                CPOL        = 1'b0,
    parameter bit                CPHA        = 1'b0,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       TX_DEPTH    = 4,
    parameter logic [DATA_W-1:0] FILL_WORD   = DATA_W'(FILL_WORD_DEFAULT),
    parameter int unsigned       CNT_W       = 8
) (
    input  logic                      clk6x,
    input  logic                      reset,
    input  logic                      spi_clk_i,
    input  logic                      spi_csn_i,
    input  logic                      spi_mosi_i,
    output logic                      spi_miso_o,
    output logic                      spi_miso_drive_o,
    output logic [DATA_W-1:0]         rx_data_o,
    output logic                      rx_valid_o,
    output logic                      rx_first_o,
    output logic [CNT_W-1:0]          rx_count_o,
    input  logic [DATA_W-1:0]         tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic [$clog2(TX_DEPTH):0] tx_level_o,
    input  logic                      tx_flush_i,
    output logic                      tx_underrun_o,
    output logic                      frame_start_o,
    output logic                      frame_end_o,
    output logic                      frame_abort_o
);

    localparam spi_mode_e   MODE  = spi_mode_e'({CPOL, CPHA});
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic                   sck_q, csn_q;
    logic                   sck_s, csn_s, mosi_s;
    spi_edge_t              edges;

    logic [0:0]        state_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] rx_sr_q, tx_sr_q, rx_data_q;
    logic [CNT_W-1:0]  rx_count_q;
    logic              rx_valid_q, rx_first_q, underrun_q, fill_pend_q;
    logic              start_q, end_q, abort_q;

    logic              start, stop, run, sample, shift, word_done, first_bit, load;
    logic              underrun_d;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty;

    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_q     <= CPOL;
            csn_q     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sck_q     <= sck_s;
            csn_q     <= csn_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign edges  = edge_sel(MODE, sck_q, sck_s);

    always_comb begin
        start     = (state_q == StIdle) && csn_q && !csn_s;
        stop      = (state_q == StActive) && !csn_q && csn_s;
        run       = (state_q == StActive) && !stop;
        word_done = (bit_cnt_q == BIT_W'(DATA_W));
        first_bit = (bit_cnt_q == '0);
        sample    = run && edges.sample;
        // A zero bit count means the MSB is already on the wire (fresh load or CPHA=1 lead-in).
        shift     = run && edges.shift && !first_bit;
        load      = start || word_done;
        // Mid-frame fill words are reported once they actually start going out.
        underrun_d = (start && fifo_empty) || (sample && first_bit && fill_pend_q);
    end

    always_ff @(posedge clk6x or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= FILL_WORD;
            rx_data_q   <= '0;
            rx_count_q  <= '0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            underrun_q  <= 1'b0;
            fill_pend_q <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            underrun_q <= underrun_d;
            start_q    <= start;
            end_q      <= stop;
            abort_q    <= stop && !first_bit && !word_done;

            if (start)     state_q <= StActive;
            else if (stop) state_q <= StIdle;

            if (load || state_q == StIdle) tx_sr_q <= fifo_empty ? FILL_WORD : fifo_head;
            else if (shift)                tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};

            if (start || stop)               fill_pend_q <= 1'b0;
            else if (word_done)              fill_pend_q <= fifo_empty;
            else if (sample && first_bit)    fill_pend_q <= 1'b0;

            if (start || stop || word_done) begin
                bit_cnt_q <= '0;
            end else if (sample) begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                rx_sr_q   <= {rx_sr_q[DATA_W-2:0], mosi_s};
            end

            if (start) begin
                rx_count_q <= '0;
            end else if (word_done) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
                rx_first_q <= (rx_count_q == '0);
                if (rx_count_q != '1) rx_count_q <= rx_count_q + CNT_W'(1);
            end
        end
    end

    spi_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .clk6x   (clk6x),
        .reset   (reset),
        .flush_i (tx_flush_i),
        .push_i  (tx_valid_i),
        .data_i  (tx_data_i),
        .pop_i   (load),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .ready_o (tx_ready_o),
        .level_o (tx_level_o)
    );

    assign spi_miso_o       = tx_sr_q[DATA_W-1];
    assign spi_miso_drive_o = (state_q == StActive);
    assign rx_data_o        = rx_data_q;
    assign rx_valid_o       = rx_valid_q;
    assign rx_first_o       = rx_first_q;
    assign rx_count_o       = rx_count_q;
    assign tx_underrun_o    = underrun_q;
    assign frame_start_o    = start_q;
    assign frame_end_o      = end_q;
    assign frame_abort_o    = abort_q;

endmodule

// File: tb/tb_spi_target_fifo.sv
// Directed bench: four 8-bit targets (modes 0..3) and one 16-bit mode-3 target on private pins.
module tb_spi_target_fifo;

    logic clk6x = 1'b0;
    logic reset;
    always #5 clk6x = ~clk6x;

    logic [4:0]  sck, csn, tx_valid;
    logic        mosi, tx_flush;
    logic [15:0] tx_data;
    logic [4:0]  miso, miso_drive, rx_valid, rx_first, tx_ready, underrun, fstart, fend, fabort;
    logic [7:0]  rx_data8 [4];
    logic [15:0] rx_data16;
    logic [7:0]  rx_count [5];
    logic [2:0]  tx_level [5];

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_target_fifo #(
            .DATA_W (8),
            .CPOL   ((g / 2) == 1),
            .CPHA   ((g % 2) == 1)
        ) u_dut (
            .clk6x            (clk6x),
            .reset            (reset),
            .spi_clk_i        (sck[g]),
            .spi_csn_i        (csn[g]),
            .spi_mosi_i       (mosi),
            .spi_miso_o       (miso[g]),
            .spi_miso_drive_o (miso_drive[g]),
            .rx_data_o        (rx_data8[g]),
            .rx_valid_o       (rx_valid[g]),
            .rx_first_o       (rx_first[g]),
            .rx_count_o       (rx_count[g]),
            .tx_data_i        (tx_data[7:0]),
            .tx_valid_i       (tx_valid[g]),
            .tx_ready_o       (tx_ready[g]),
            .tx_level_o       (tx_level[g]),
            .tx_flush_i       (tx_flush),
            .tx_underrun_o    (underrun[g]),
            .frame_start_o    (fstart[g]),
            .frame_end_o      (fend[g]),
            .frame_abort_o    (fabort[g])
        );
    end

    spi_target_fifo #(
        .DATA_W (16),
        .CPOL   (1'b1),
        .CPHA   (1'b1)
    ) u_dut16 (
        .clk6x            (clk6x),
        .reset            (reset),
        .spi_clk_i        (sck[4]),
        .spi_csn_i        (csn[4]),
        .spi_mosi_i       (mosi),
        .spi_miso_o       (miso[4]),
        .spi_miso_drive_o (miso_drive[4]),
        .rx_data_o        (rx_data16),
        .rx_valid_o       (rx_valid[4]),
        .rx_first_o       (rx_first[4]),
        .rx_count_o       (rx_count[4]),
        .tx_data_i        (tx_data),
        .tx_valid_i       (tx_valid[4]),
        .tx_ready_o       (tx_ready[4]),
        .tx_level_o       (tx_level[4]),
        .tx_flush_i       (tx_flush),
        .tx_underrun_o    (underrun[4]),
        .frame_start_o    (fstart[4]),
        .frame_end_o      (fend[4]),
        .frame_abort_o    (fabort[4])
    );

    // Strobe counters and a 4-deep log of received words per target.
    int          vcnt [5] = '{default: 0};
    int          ucnt [5] = '{default: 0};
    int          scnt [5] = '{default: 0};
    int          ecnt [5] = '{default: 0};
    int          acnt [5] = '{default: 0};
    logic [15:0] log_d [5][4];
    logic        log_f [5][4];

    always @(negedge clk6x) begin
        for (int i = 0; i < 5; i++) begin
            if (rx_valid[i]) begin
                log_d[i][vcnt[i][1:0]] <= (i == 4) ? rx_data16 : {8'h00, rx_data8[i[1:0]]};
                log_f[i][vcnt[i][1:0]] <= rx_first[i];
                vcnt[i] <= vcnt[i] + 1;
            end
            if (underrun[i]) ucnt[i] <= ucnt[i] + 1;
            if (fstart[i])   scnt[i] <= scnt[i] + 1;
            if (fend[i])     ecnt[i] <= ecnt[i] + 1;
            if (fabort[i])   acnt[i] <= acnt[i] + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag, input int idx, input int slot,
                            input logic [15:0] d, input logic f);
        check({tag, "_data"}, log_d[idx][slot % 4], d);
        check({tag, "_first"}, log_f[idx][slot % 4], f);
    endtask

    task automatic half_wait();
        repeat (6) @(negedge clk6x);
    endtask

    task automatic push(input int idx, input logic [15:0] d);
        tx_data       = d;
        tx_valid[idx] = 1'b1;
        @(negedge clk6x);
        tx_valid[idx] = 1'b0;
    endtask

    task automatic sel(input int idx);
        csn[idx] = 1'b0;
        half_wait();
    endtask

    task automatic desel(input int idx);
        half_wait();
        csn[idx] = 1'b1;
        repeat (10) @(negedge clk6x);
    endtask

    // Host side: MSB first, nbits of a w-bit word, MISO captured at the host sample edge.
    task automatic xfer(input int idx, input int w, input int nbits, input logic [15:0] dout,
                        output logic [15:0] din);
        logic cpol;
        logic cpha;
        cpol = (idx >= 2);
        cpha = (idx == 1) || (idx == 3) || (idx == 4);
        din  = '0;
        for (int b = w - 1; b >= w - nbits; b--) begin
            if (!cpha) begin
                mosi = dout[b];
                half_wait();
                sck[idx] = ~cpol;
                din[b] = miso[idx];
                half_wait();
                sck[idx] = cpol;
            end else begin
                sck[idx] = ~cpol;
                mosi = dout[b];
                half_wait();
                sck[idx] = cpol;
                din[b] = miso[idx];
                half_wait();
            end
        end
    endtask

    initial begin
        logic [15:0] g0, g1, g2, g3;
        int v, u, e, a, s;

        reset = 1'b1; sck = 5'b11100; csn = '1; tx_valid = '0;
        tx_flush = 1'b0; mosi = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk6x);
        check("rst_miso8", miso[0], 1);
        check("rst_miso16", miso[4], 0);
        check("rst_drive", miso_drive, 0);
        check("rst_ready", tx_ready, 5'h1F);
        check("rst_level", tx_level[0], 0);
        check("rst_strobes", {rx_valid, rx_first, underrun, fstart, fend, fabort}, 0);
        check("rst_count", rx_count[0], 0);
        check("rst_rxdata", rx_data8[0], 0);
        reset = 1'b0;
        repeat (5) @(negedge clk6x);

        // Mode 0 single word
        push(0, 16'h00A5);
        check("t1_level", tx_level[0], 1);
        v = vcnt[0]; u = ucnt[0]; e = ecnt[0]; a = acnt[0]; s = scnt[0];
        sel(0);
        check("t1_start", scnt[0] - s, 1);
        check("t1_drive_on", miso_drive[0], 1);
        xfer(0, 8, 8, 16'h003C, g0);
        desel(0);
        check_rx("t1_rx", 0, v, 16'h003C, 1'b1);
        check("t1_nvalid", vcnt[0] - v, 1);
        check("t1_count", rx_count[0], 1);
        check("t1_miso", g0, 16'h00A5);
        check("t1_end", ecnt[0] - e, 1);
        check("t1_abort", acnt[0] - a, 0);
        check("t1_underrun", ucnt[0] - u, 0);
        check("t1_drive_off", miso_drive[0], 0);
        check("t1_level_end", tx_level[0], 0);

        // Two words in each of the four modes
        for (int m = 0; m < 4; m++) begin
            push(m, 16'h0081);
            push(m, 16'h007E);
            check($sformatf("m%0d_level2", m), tx_level[m], 2);
            v = vcnt[m];
            sel(m);
            xfer(m, 8, 8, 16'h0012, g0);
            xfer(m, 8, 8, 16'h0034, g1);
            desel(m);
            check_rx($sformatf("m%0d_w0", m), m, v, 16'h0012, 1'b1);
            check_rx($sformatf("m%0d_w1", m), m, v + 1, 16'h0034, 1'b0);
            check($sformatf("m%0d_miso", m), {g0[7:0], g1[7:0]}, 16'h817E);
            check($sformatf("m%0d_count", m), rx_count[m], 2);
            check($sformatf("m%0d_level0", m), tx_level[m], 0);
        end

        // Underrun: three words with an empty FIFO
        u = ucnt[0];
        sel(0);
        xfer(0, 8, 8, 16'h0001, g0);
        xfer(0, 8, 8, 16'h0002, g1);
        xfer(0, 8, 8, 16'h0003, g2);
        desel(0);
        check("ur_miso", {g0[7:0], g1[7:0], g2[7:0]}, 24'hFFFFFF);
        check("ur_pulses", ucnt[0] - u, 3);
        check("ur_count", rx_count[0], 3);

        // Abort after five bits, then a clean frame
        v = vcnt[0]; e = ecnt[0]; a = acnt[0];
        sel(0);
        xfer(0, 8, 5, 16'h00A8, g0);
        desel(0);
        check("ab_end", ecnt[0] - e, 1);
        check("ab_abort", acnt[0] - a, 1);
        check("ab_novalid", vcnt[0] - v, 0);
        sel(0);
        xfer(0, 8, 8, 16'h005A, g0);
        desel(0);
        check_rx("ab_next", 0, v, 16'h005A, 1'b1);
        check("ab_next_count", rx_count[0], 1);

        // FIFO boundaries
        for (int k = 1; k <= 4; k++) push(0, 16'(k * 'h11));
        check("ff_full_level", tx_level[0], 4);
        check("ff_full_ready", tx_ready[0], 0);
        push(0, 16'h0055);
        check("ff_full_ignore", tx_level[0], 4);
        tx_flush = 1'b1; tx_valid[0] = 1'b1; tx_data = 16'h0066;
        @(negedge clk6x);
        tx_flush = 1'b0; tx_valid[0] = 1'b0;
        check("ff_flush", tx_level[0], 0);
        for (int k = 1; k <= 3; k++) push(0, 16'(k * 'h11));
        check("ff_level3", tx_level[0], 3);
        // Push lands on the same clock as the frame-start pop (two-stage CSN synchroniser).
        csn[0] = 1'b0;
        @(negedge clk6x);
        @(negedge clk6x);
        tx_data = 16'h0055; tx_valid[0] = 1'b1;
        @(negedge clk6x);
        tx_valid[0] = 1'b0;
        check("ff_pushpop", tx_level[0], 3);
        half_wait();
        xfer(0, 8, 8, 16'h0000, g0);
        xfer(0, 8, 8, 16'h0000, g1);
        xfer(0, 8, 8, 16'h0000, g2);
        xfer(0, 8, 8, 16'h0000, g3);
        desel(0);
        check("ff_order", {g0[7:0], g1[7:0], g2[7:0], g3[7:0]}, 32'h11223355);

        // 16-bit mode 3
        push(4, 16'hBEEF);
        v = vcnt[4];
        sel(4);
        xfer(4, 16, 16, 16'h1234, g0);
        desel(4);
        check_rx("w16", 4, v, 16'h1234, 1'b1);
        check("w16_miso", g0, 16'hBEEF);
        check("w16_count", rx_count[4], 1);

        // Asynchronous reset in the middle of a word
        push(4, 16'h0F0F);
        e = ecnt[4];
        sel(4);
        xfer(4, 16, 6, 16'hAAAA, g0);
        #2 reset = 1'b1;
        @(negedge clk6x);
        check("ar_drive", miso_drive[4], 0);
        check("ar_count", rx_count[4], 0);
        check("ar_level", tx_level[4], 0);
        check("ar_miso", miso[4], 0);
        check("ar_rxdata", rx_data16, 0);
        check("ar_ready", tx_ready[4], 1);
        csn[4] = 1'b1; sck[4] = 1'b1;
        repeat (3) @(negedge clk6x);
        reset = 1'b0;
        repeat (10) @(negedge clk6x);
        check("ar_noend", ecnt[4] - e, 0);
        check("ar_idle_drive", miso_drive[4], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
